// File: rtl/aes_pkg.sv
// aes_pkg: types, constants and helpers shared by the AES key-schedule blocks.
//   state_t   : 128-bit state matrix; s[r][c] is FIPS-197 byte 4c+r, so a
//               column is one 32-bit key word.
//   fsm_t     : expander control states.
//   xtime     : multiply by x in GF(2^8); used to step the round constant.
package aes_pkg;

    typedef logic [0:3][0:3][7:0] state_t;

    localparam int         AES_NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT      = 8'h01;
    localparam logic [7:0] RCON_POLY      = 8'h1b;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expander_round.sv
// roundKeyGen: combinational single-round AES-128 key expansion stage.
//   key_in  : previous round key (state matrix layout)
//   rnd     : round constant for this step
//   key_out : next round key
// One SubWord (four S-boxes on the rotated last column) feeds an XOR chain
// across the four columns.
module roundKeyGen
    import aes_pkg::*;
(
    input  state_t     key_in,
    input  logic [7:0] rnd,
    output state_t     key_out
);

    // Forward S-box, byte x lives at bits {~x,3'b111} down to {~x,3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction

    logic [0:3][7:0] temp;

    // Row gi of the new column 0 takes the S-box of row gi+1 of the old
    // column 3 (RotWord); rcon only touches the top row.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign temp[gi]       = sbox(key_in[(gi + 1) % 4][3]) ^ ((gi == 0) ? rnd : 8'h00);
            assign key_out[gi][0] = key_in[gi][0] ^ temp[gi];
            assign key_out[gi][1] = key_in[gi][1] ^ key_out[gi][0];
            assign key_out[gi][2] = key_in[gi][2] ^ key_out[gi][1];
            assign key_out[gi][3] = key_in[gi][3] ^ key_out[gi][2];
        end
    endgenerate

endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: sequential AES-128 key schedule with a round-key store.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_in     : cipher key (state matrix), accepted on key_valid && key_ready
//   key_ready  : a key can be accepted (IDLE or DONE, never in reset)
//   busy       : expansion running
//   keys_valid : all NUM_ROUNDS+1 entries hold the last accepted key's schedule
//   rk_idx     : round-key read index; out-of-range indices read zero
//   rk_out     : registered round key for rk_idx (one cycle latency)
// One expansion round per clock; entry n is written n cycles after accept.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  state_t     key_in,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    output logic       keys_valid,
    input  logic [3:0] rk_idx,
    output state_t     rk_out
);

    fsm_t       state_reg, state_next;
    logic [3:0] cnt_reg;
    logic [7:0] rcon_reg;
    state_t     work_reg;
    state_t     rk_out_reg;
    state_t     rf_reg [0:NUM_ROUNDS];
    state_t     rkg_out;

    logic                  ready_state;
    logic                  accept;
    logic                  expand_step;
    logic [NUM_ROUNDS:0]   wr_en;

    roundKeyGen u_round (
        .key_in  (work_reg),
        .rnd     (rcon_reg),
        .key_out (rkg_out)
    );

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        ready_state = 1'b0;
        busy        = 1'b0;
        keys_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_state = 1'b1;
                if (accept) state_next = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (cnt_reg == 4'(NUM_ROUNDS)) state_next = DONE;
            end
            DONE: begin
                ready_state = 1'b1;
                keys_valid  = 1'b1;
                if (accept) state_next = EXPAND;
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is held low for the whole time reset is asserted, not just
    // after the state register has been cleared.
    assign key_ready   = rst_n && ready_state;
    assign accept      = key_valid && key_ready;
    assign expand_step = (state_reg == EXPAND);

    // ------------------------------------------------------------ round state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg <= '0;
            cnt_reg  <= '0;
            rcon_reg <= RCON_INIT;
        end else if (accept) begin
            work_reg <= key_in;
            cnt_reg  <= 4'd1;
            rcon_reg <= RCON_INIT;
        end else if (expand_step) begin
            work_reg <= rkg_out;
            cnt_reg  <= cnt_reg + 4'd1;
            rcon_reg <= xtime(rcon_reg);
        end
    end

    // ------------------------------------------------------------ register file
    // Entry 0 is loaded on accept; entry n on the EXPAND cycle whose
    // counter equals n.
    genvar gi;
    generate
        for (gi = 0; gi <= NUM_ROUNDS; gi++) begin : g_wr
            if (gi == 0) begin : g_key
                assign wr_en[gi] = accept;
            end else begin : g_round
                assign wr_en[gi] = expand_step && (cnt_reg == 4'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) rf_reg[i] <= '0;
        end else begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                if (wr_en[i]) rf_reg[i] <= (i == 0) ? key_in : rkg_out;
            end
        end
    end

    // Registered read; a same-edge write is not forwarded, so the read
    // shows the entry's previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         rk_out_reg <= '0;
        else if (rk_idx <= 4'(NUM_ROUNDS))  rk_out_reg <= rf_reg[rk_idx];
        else                                rk_out_reg <= '0;
    end

    assign rk_out = rk_out_reg;

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential AES-128 key-schedule engine. It accepts a 128-bit cipher key through a valid/ready handshake and iterates the single-round key-expansion stage once per clock for 10 cycles, generating the Rcon sequence internally. It stores all 11 round keys in a register file and serves them by round index to the downstream cipher round datapath.

## Interface
- NUM_ROUNDS, 10: number of expansion rounds (fixed for AES-128; the entry count is NUM_ROUNDS+1).
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- key_in  in  [7:0] [0:3][0:3]  cipher key as a state matrix; key_in[r][c] = FIPS-197 key byte 4c+r
- key_valid  in  1  key_in is valid
- key_ready  out  1  expander can accept a key
- busy  out  1  expansion in progress
- keys_valid  out  1  all 11 entries hold the schedule of the last accepted key
- rk_idx  in  4  round-key read index, 0..10
- rk_out  out  [7:0] [0:3][0:3]  registered round key for rk_idx, same matrix layout as key_in

## Operation
- FSM states: IDLE, EXPAND, DONE. Reset puts the FSM in IDLE.
- IDLE: key_ready=1, busy=0, keys_valid=0.
- DONE: key_ready=1, busy=0, keys_valid=1.
- EXPAND: key_ready=0, busy=1, keys_valid=0. key_valid is ignored in this state; no buffering of a pending key.
- Accept when key_valid && key_ready, from IDLE or DONE:
  - key_in is written to entry 0 and to the working register.
  - The round counter is set to 1 and rcon to 8'h01.
  - The FSM goes to EXPAND.
- Each EXPAND cycle:
  - The expansion stage takes the working register and rnd=rcon.
  - Its result is written to the working register and to entry[counter].
  - The counter increments.
  - rcon updates by GF(2^8) xtime: rcon<<1, XOR 8'h1b if bit 7 was set. The sequence is 01,02,04,08,10,20,40,80,1b,36.
  - When the counter is 10, the FSM goes to DONE after the write.
- Read port:
  - rk_out is registered from entry[rk_idx] at every edge, in any state.
  - rk_idx 11..15 returns all-zero.
  - Reads during EXPAND return whatever the entry currently holds. The consumer must qualify reads with keys_valid.
- Reload from DONE: keys_valid falls on the accepting edge. Entries are overwritten progressively.
- Reset values: all entries, working register, rk_out = 0; counter=0; rcon=8'h01; key_ready=0 while rst_n is low, 1 after release (IDLE); busy=0; keys_valid=0.

## Timing
- Accept on edge T:
  - entry 0 is valid after T.
  - entry n is written at edge T+n.
  - keys_valid=1 after edge T+10.
  - key_ready returns to 1 after T+10, so the next key can be accepted at edge T+11.
- Read latency: 1 cycle. rk_idx sampled at edge E gives rk_out valid after E.
- Read and write to the same entry on the same edge: rk_out shows the pre-write contents.
- rst_n assertion mid-EXPAND immediately clears the FSM, counters, all entries and outputs. No partial schedule survives.
- Combinational path per cycle: one SubWord (4 S-boxes) plus an XOR chain. This path is the critical path, with no extra pipelining.

## Structure
- Shared package aes_pkg:
  - state_t typedef: logic [7:0] [0:3][0:3].
  - AES_NUM_ROUNDS = 10.
  - RCON_INIT = 8'h01.
  - RCON_POLY = 8'h1b.
  - xtime function.
- One sub-module instance: roundKeyGen, the existing combinational single-round expansion stage. It is driven by the working register and rcon.
- The FSM, counter, rcon register, 11-entry register file and read mux live in aes_key_expander.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - After keys_valid, rk_idx=1 gives a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_idx=0 returns the key.
- Rcon and timing: probe rcon across EXPAND for 01,02,04,08,10,20,40,80,1b,36. Check keys_valid rises exactly 10 cycles after the accept edge.
- Handshake: hold key_valid high with a different key during EXPAND. It is not accepted and the schedule matches the first key. Reload from DONE with an all-zero key; rk_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset mid-operation: assert rst_n low at round 5. Immediately keys_valid=0, busy=0, rk_out=0, and all entries read 0 after release.
- Read boundaries: rk_idx=11 and 15 return 0. Read entry 3 on its write edge, expecting the old value, then the new value the next cycle.
